// File: rtl/vec3_len_sq_if.sv
// Handshake bundle for vec3_len_sq: vector input channel and result output channel.
// The master drives vectors and result backpressure; the slave is the length engine.
interface vec3_len_sq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] len_sq;
  logic             ovf;

  modport master (
    output in_valid, x, y, z, out_ready,
    input  in_ready, out_valid, len_sq, ovf
  );

  modport slave (
    input  in_valid, x, y, z, out_ready,
    output in_ready, out_valid, len_sq, ovf
  );
endinterface

// File: rtl/vec3_len_sq.sv
// Squared length x^2+y^2+z^2 of a signed Q16.48 vector using one multiplier
// iterated over three cycles, with saturation to the largest positive value.
module vec3_len_sq #(
  parameter int WIDTH = 64,
  parameter int FRAC  = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  vec3_len_sq_if.slave  bus,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ_X = 3'd1,
    SQ_Y = 3'd2,
    SQ_Z = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a raised out_valid holds its
  // data stable until the transfer completes.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [WIDTH-1:0] len_sq_q, len_sq_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0]   op;
  logic [2*WIDTH-1:0] op_ext;
  logic [2*WIDTH-1:0] prod;
  logic               sq_sat;
  logic [WIDTH-1:0]   sq;
  logic [WIDTH:0]     sum;
  logic               sum_sat;
  logic [WIDTH:0]     acc_next;
  logic               ovf_next;
  logic               unused_prod_lsbs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      len_sq_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      len_sq_q  <= len_sq_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SQ_X;
      SQ_X:    state_d = SQ_Y;
      SQ_Y:    state_d = SQ_Z;
      SQ_Z:    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.len_sq    = len_sq_q;
    bus.ovf       = ovf_q;
    dbg_state     = state_q;
  end

  // Shared squarer. Sign-extending to the full product width lets an unsigned
  // multiply yield the exact signed square, which is always below 2^127.
  always_comb begin
    case (state_q)
      SQ_Y:    op = y_q;
      SQ_Z:    op = z_q;
      default: op = x_q;
    endcase
    op_ext   = {{WIDTH{op[WIDTH-1]}}, op};
    prod     = op_ext * op_ext;
    sq_sat   = |prod[2*WIDTH-1:FRAC+WIDTH-1];
    sq       = sq_sat ? SAT_MAX : prod[FRAC+WIDTH-1:FRAC];
    sum      = acc_q + {1'b0, sq};
    sum_sat  = (sum > {1'b0, SAT_MAX});
    acc_next = sum_sat ? {1'b0, SAT_MAX} : sum;
    ovf_next = acc_ovf_q | sq_sat | sum_sat;
  end

  assign unused_prod_lsbs = ^prod[FRAC-1:0];

  // Register updates: operands latch on accept, result publishes on entry to DONE
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    len_sq_d  = len_sq_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d       = bus.x;
          y_d       = bus.y;
          z_d       = bus.z;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
        end
      end
      SQ_X, SQ_Y: begin
        acc_d     = acc_next;
        acc_ovf_d = ovf_next;
      end
      SQ_Z: begin
        acc_d     = acc_next;
        acc_ovf_d = ovf_next;
        len_sq_d  = acc_next[WIDTH-1:0];
        ovf_d     = ovf_next;
      end
      default: ;
    endcase
  end

  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_ready && bus.out_valid));

  a_result_nonneg: assert property (@(posedge clk) disable iff (!rst_n)
    bus.out_valid |-> !bus.len_sq[WIDTH-1]);

  a_result_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.len_sq) && $stable(bus.ovf)));

endmodule

// File: tb/tb_vec3_len_sq.sv
// Directed bench for vec3_len_sq: vector table with hand-computed squared
// lengths, plus backpressure and mid-operation reset sequences.
module tb_vec3_len_sq;

  localparam int W = 64;
  localparam logic [W-1:0] SATV = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam int NVEC = 12;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic [W-1:0] len;
    logic         ovf;
    string        name;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  vec3_len_sq_if #(.WIDTH(W)) bus ();

  vec3_len_sq #(.WIDTH(W), .FRAC(48)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_vec  = 0;
  int           n_miss = 0;
  logic [W:0]   exp_q[$];
  vec_t         vecs[NVEC];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.x = {$urandom, $urandom};
    bus.y = {$urandom, $urandom};
    bus.z = {$urandom, $urandom};
  endtask

  // Accept one vector, wait for its result with out_ready=1, check it and the return to IDLE.
  task automatic apply_vec(input vec_t v);
    int         lat;
    logic [W:0] e;
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check({v.name, " in_ready"}, W'(bus.in_ready), W'(1));
    bus.x = v.x; bus.y = v.y; bus.z = v.z;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back({v.ovf, v.len});
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check({v.name, " latency"}, W'(lat), W'(3));
    if (bus.out_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({v.name, " len_sq"}, bus.len_sq, e[W-1:0]);
      check({v.name, " ovf"}, W'(bus.ovf), W'(e[W]));
    end else begin
      check({v.name, " out_valid timeout"}, W'(bus.out_valid), W'(1));
    end
    @(posedge clk); @(negedge clk);
    check({v.name, " out_valid after hs"}, W'(bus.out_valid), W'(0));
    check({v.name, " in_ready after hs"}, W'(bus.in_ready), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] bp_len;
    logic         bp_ovf;
    vec_t         v;
    int           lat;

    vecs[0]  = '{64'h0001_0000_0000_0000, 64'h0002_0000_0000_0000, 64'h0002_0000_0000_0000, 64'h0009_0000_0000_0000, 1'b0, "v_1_2_2"};
    vecs[1]  = '{64'hFFFD_0000_0000_0000, 64'h0, 64'h0, 64'h0009_0000_0000_0000, 1'b0, "v_neg3"};
    vecs[2]  = '{64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 64'h0000_8000_0000_0000, 64'h0000_C000_0000_0000, 1'b0, "v_half"};
    vecs[3]  = '{64'h0000_0000_0000_0001, 64'h0, 64'h0, 64'h0, 1'b0, "v_lsb_trunc"};
    vecs[4]  = '{64'h00C8_0000_0000_0000, 64'h0, 64'h0, SATV, 1'b1, "v_200_sat"};
    vecs[5]  = '{64'h00B5_0000_0000_0000, 64'h0, 64'h0, 64'h7FF9_0000_0000_0000, 1'b0, "v_181_fit"};
    vecs[6]  = '{64'h006E_0000_0000_0000, 64'h006E_0000_0000_0000, 64'h006E_0000_0000_0000, SATV, 1'b1, "v_110_sum_sat"};
    vecs[7]  = '{64'h8000_0000_0000_0000, 64'h0, 64'h0, SATV, 1'b1, "v_most_neg"};
    vecs[8]  = '{64'hFFFE_8000_0000_0000, 64'h0002_8000_0000_0000, 64'hFFFF_C000_0000_0000, 64'h0008_9000_0000_0000, 1'b0, "v_mixed"};
    vecs[9]  = '{SATV, 64'h0001_0000_0000_0000, 64'h0, SATV, 1'b1, "v_max_plus_one"};
    vecs[10] = '{64'h0000_0000_0100_0000, 64'h0000_0000_0100_0000, 64'h0000_0000_0100_0000, 64'h0000_0000_0000_0003, 1'b0, "v_2m24"};
    vecs[11] = '{64'h0, 64'h0, 64'h0, 64'h0, 1'b0, "v_zero"};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.x = '0; bus.y = '0; bus.z = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", W'(bus.in_ready), W'(1));
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset len_sq", bus.len_sq, W'(0));
    check("reset ovf", W'(bus.ovf), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) apply_vec(vecs[i]);

    // Backpressure: result held for 10 cycles while inputs churn
    bus.out_ready = 1'b0;
    bus.x = 64'h0001_0000_0000_0000; bus.y = 64'h0001_0000_0000_0000; bus.z = 64'h0001_0000_0000_0000;
    bus.in_valid = 1'b1;
    bp_len = 64'h0003_0000_0000_0000;
    bp_ovf = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    check("bp latency", W'(lat), W'(3));
    for (int c = 0; c < 10; c++) begin
      check("bp out_valid", W'(bus.out_valid), W'(1));
      check("bp len_sq", bus.len_sq, bp_len);
      check("bp ovf", W'(bus.ovf), W'(bp_ovf));
      check("bp in_ready", W'(bus.in_ready), W'(0));
      scramble_inputs();
      bus.in_valid = c[0];
      @(posedge clk); @(negedge clk);
    end
    // in_valid stays high across the handshake edge; it must not be taken there
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp hs out_valid", W'(bus.out_valid), W'(0));
    check("bp hs in_ready", W'(bus.in_ready), W'(1));
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      check("bp single hs", W'(bus.out_valid), W'(0));
    end

    // Asynchronous reset while squaring y
    bus.x = 64'h006E_0000_0000_0000; bus.y = 64'h006E_0000_0000_0000; bus.z = 64'h006E_0000_0000_0000;
    bus.in_valid = 1'b1;
    exp_q.push_back({1'b1, SATV});
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid state SQ_Y", W'(dbg_state), W'(2));
    #2 rst_n = 1'b0;
    #1;
    check("mid rst out_valid", W'(bus.out_valid), W'(0));
    check("mid rst len_sq", bus.len_sq, W'(0));
    check("mid rst ovf", W'(bus.ovf), W'(0));
    check("mid rst in_ready", W'(bus.in_ready), W'(1));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      check("post rst no result", W'(bus.out_valid), W'(0));
    end
    v = '{64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 64'h0003_0000_0000_0000, 1'b0, "v_post_rst"};
    apply_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
